// File: rtl/ffb_pkg.sv
// Shared mode encoding and the per-channel next-state rule for the multimode flip-flop bank.
package ffb_pkg;

  typedef enum logic [1:0] {
    M_T  = 2'b00,
    M_D  = 2'b01,
    M_JK = 2'b10,
    M_SR = 2'b11
  } mode_e;

  // Next state of one enabled, non-loading channel. S=R=1 holds (the error is flagged elsewhere).
  function automatic logic ff_next(input mode_e m, input logic q, input logic a, input logic b);
    logic r;
    r = q;
    case (m)
      M_T:  r = q ^ a;
      M_D:  r = a;
      M_JK: begin
        case ({a, b})
          2'b01:   r = 1'b0;
          2'b10:   r = 1'b1;
          2'b11:   r = ~q;
          default: r = q;
        endcase
      end
      M_SR: begin
        case ({a, b})
          2'b01:   r = 1'b0;
          2'b10:   r = 1'b1;
          default: r = q;
        endcase
      end
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ffb_cell.sv
// One channel of the bank: state bit, change flag, saturating change counter, S=R error flag.
module ffb_cell
  import ffb_pkg::*;
#(
  parameter int   CNT_W     = 4,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             load,
  input  logic             load_val,
  input  logic             cnt_clr,
  output logic             q,
  output logic             chg,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic q_next;
  logic changed;

  always_comb begin
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      q_next = ff_next(mode_e'(mode), q, a, b);
    end else begin
      q_next = q;
    end
  end

  assign changed = q_next ^ q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= RESET_BIT;
      chg <= 1'b0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      q   <= q_next;
      chg <= changed;
      err <= (mode_e'(mode) == M_SR) & en & a & b & ~load;
      // Clear beats a simultaneous change; the counter sticks at its maximum.
      if (cnt_clr) begin
        cnt <= '0;
      end else if (changed && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multimode_ff_bank.sv
// WIDTH-channel T/D/JK/SR storage bank with parallel load, change flags and toggle counters.
module multimode_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       en,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_val,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_n,
  output logic [WIDTH-1:0]       chg,
  output logic                   sr_err,
  output logic [WIDTH*CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] err;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      ffb_cell #(
        .CNT_W     (CNT_W),
        .RESET_BIT (RESET_VAL[gi])
      ) u_cell (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .en       (en[gi]),
        .a        (a[gi]),
        .b        (b[gi]),
        .load     (load),
        .load_val (load_val[gi]),
        .cnt_clr  (cnt_clr),
        .q        (q[gi]),
        .chg      (chg[gi]),
        .cnt      (cnt[gi*CNT_W +: CNT_W]),
        .err      (err[gi])
      );
    end
  endgenerate

  assign q_n    = ~q;
  assign sr_err = |err;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Randomized and directed bench for multimode_ff_bank against a per-channel behavioural model.
module tb_multimode_ff_bank;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [W-1:0]  en, a, b, load_val;
  logic          load, cnt_clr;
  logic [W-1:0]  q, q_n, chg;
  logic          sr_err;
  logic [W*CW-1:0] cnt;

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit [W-1:0] m_q;
  bit [W-1:0] m_chg;
  bit         m_err;
  int         m_cnt [W];

  always #5 clk = ~clk;

  multimode_ff_bank #(.WIDTH(W), .CNT_W(CW), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b), .load(load),
    .load_val(load_val), .cnt_clr(cnt_clr), .q(q), .q_n(q_n), .chg(chg),
    .sr_err(sr_err), .cnt(cnt)
  );

  function automatic bit model_bit(int m, bit qi, bit ai, bit bi);
    if (m == 0) return qi ^ ai;
    if (m == 1) return ai;
    if (m == 2) begin
      if (ai && bi) return !qi;
      if (ai) return 1'b1;
      if (bi) return 1'b0;
      return qi;
    end
    if (ai && !bi) return 1'b1;
    if (bi && !ai) return 1'b0;
    return qi;
  endfunction

  function automatic logic [W*CW-1:0] model_cnt_vec();
    logic [W*CW-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_q = 8'h00; m_chg = '0; m_err = 1'b0;
    for (int i = 0; i < W; i++) m_cnt[i] = 0;
  endtask

  task automatic compare_all(input string tag);
    n_vec++;
    if (q !== m_q) begin n_err++; $display("FAIL %s q: got %h want %h", tag, q, m_q); end
    n_vec++;
    if (q_n !== ~m_q) begin n_err++; $display("FAIL %s q_n: got %h want %h", tag, q_n, ~m_q); end
    n_vec++;
    if (chg !== m_chg) begin n_err++; $display("FAIL %s chg: got %h want %h", tag, chg, m_chg); end
    n_vec++;
    if (sr_err !== m_err) begin n_err++; $display("FAIL %s sr_err: got %b want %b", tag, sr_err, m_err); end
    n_vec++;
    if (cnt !== model_cnt_vec()) begin
      n_err++; $display("FAIL %s cnt: got %h want %h", tag, cnt, model_cnt_vec());
    end
  endtask

  // One clock edge with the currently driven inputs; model advances then all outputs are checked.
  task automatic step(input string tag);
    bit [W-1:0] nq;
    bit         e;
    e = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (load) nq[i] = load_val[i];
      else if (en[i]) nq[i] = model_bit(int'(mode), m_q[i], a[i], b[i]);
      else nq[i] = m_q[i];
      if (!load && mode == 2'd3 && en[i] && a[i] && b[i]) e = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      if (cnt_clr) m_cnt[i] = 0;
      else if (nq[i] != m_q[i] && m_cnt[i] < CMAX) m_cnt[i]++;
    end
    m_chg = nq ^ m_q;
    m_q   = nq;
    m_err = e;
    compare_all(tag);
    $display("%s mode=%0d en=%h a=%h b=%h load=%b lv=%h clr=%b -> q=%h chg=%h err=%b cnt=%h",
             tag, mode, en, a, b, load, load_val, cnt_clr, q, chg, sr_err, cnt);
  endtask

  task automatic idle_inputs();
    mode = 2'd0; en = '0; a = '0; b = '0; load = 1'b0; load_val = '0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_vec++;
    if (q !== 8'h00 || q_n !== 8'hFF) begin n_err++; $display("FAIL reset q/q_n: got %h/%h want 00/ff", q, q_n); end
    n_vec++;
    if (chg !== 8'h00 || sr_err !== 1'b0 || cnt !== '0) begin
      n_err++; $display("FAIL reset flags: chg=%h err=%b cnt=%h want 0", chg, sr_err, cnt);
    end
    $display("reset -> q=%h q_n=%h chg=%h err=%b cnt=%h", q, q_n, chg, sr_err, cnt);
  endtask

  task automatic test_t_mode();
    logic [W-1:0] exp_q [3];
    exp_q[0] = 8'h0F; exp_q[1] = 8'h00; exp_q[2] = 8'h0F;
    mode = 2'd0; en = 8'hFF; a = 8'h0F;
    for (int k = 0; k < 3; k++) begin
      step("t_mode");
      n_vec++;
      if (q !== exp_q[k] || chg !== 8'h0F) begin
        n_err++; $display("FAIL t_mode edge%0d: q=%h chg=%h want %h/0f", k, q, chg, exp_q[k]);
      end
    end
    n_vec++;
    if (cnt !== 32'h0000_3333) begin n_err++; $display("FAIL t_mode cnt: got %h want 00003333", cnt); end
  endtask

  task automatic test_jk();
    logic [W-1:0] hi;
    mode = 2'd2; en = 8'h01;
    hi = q & 8'hFE;
    a = 8'hFF; b = 8'h00; step("jk_set");
    n_vec++; if (q !== (hi | 8'h01)) begin n_err++; $display("FAIL jk_set: got %h want %h", q, hi | 8'h01); end
    a = 8'hAA; b = 8'h55; step("jk_rst");
    n_vec++; if (q !== hi) begin n_err++; $display("FAIL jk_rst: got %h want %h", q, hi); end
    a = 8'hFF; b = 8'hFF; step("jk_tog");
    n_vec++; if (q !== (hi | 8'h01)) begin n_err++; $display("FAIL jk_tog: got %h want %h", q, hi | 8'h01); end
  endtask

  task automatic test_sr();
    logic [W-1:0] held;
    mode = 2'd3; en = 8'hFF; a = 8'h80; b = 8'h80;
    held = q;
    step("sr_both");
    n_vec++;
    if (q !== held || sr_err !== 1'b1) begin
      n_err++; $display("FAIL sr_both: q=%h err=%b want %h/1", q, sr_err, held);
    end
    a = 8'h00; b = 8'h00; step("sr_idle");
    n_vec++; if (sr_err !== 1'b0) begin n_err++; $display("FAIL sr_pulse: err=%b want 0", sr_err); end
    a = 8'h80; b = 8'h80; load = 1'b1; load_val = 8'hA5;
    step("sr_load");
    n_vec++;
    if (q !== 8'hA5 || sr_err !== 1'b0) begin
      n_err++; $display("FAIL sr_load: q=%h err=%b want a5/0", q, sr_err);
    end
    load = 1'b0;
  endtask

  task automatic test_saturation();
    mode = 2'd0; en = 8'hFF; a = 8'h01; b = 8'h00;
    for (int k = 0; k < 20; k++) step("sat");
    n_vec++; if (cnt[3:0] !== 4'd15) begin n_err++; $display("FAIL sat cnt0: got %0d want 15", cnt[3:0]); end
    cnt_clr = 1'b1; step("sat_clr");
    n_vec++; if (cnt[3:0] !== 4'd0) begin n_err++; $display("FAIL sat_clr cnt0: got %0d want 0", cnt[3:0]); end
    cnt_clr = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      mode     = 2'($urandom_range(0, 3));
      en       = 8'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
      load     = ($urandom_range(0, 7) == 0);
      load_val = 8'($urandom);
      cnt_clr  = ($urandom_range(0, 15) == 0);
      step("rand");
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    mode = 2'd0; en = 8'hFF; a = 8'h5A;
    repeat (3) step("pre_rst");
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (q !== 8'h00 || cnt !== '0 || chg !== 8'h00) begin
      n_err++; $display("FAIL async_rst: q=%h cnt=%h chg=%h want 0", q, cnt, chg);
    end
    $display("async_rst -> q=%h cnt=%h chg=%h", q, cnt, chg);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step("post_rst");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_t_mode();
    test_jk();
    test_sr();
    test_saturation();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
